mac_reduce_accumulate: RTL and testbench

- Consumer end of the conv-layer multiply stage: takes the six signed products per tap beat (slot 0 = pre-shifted bias, slots 1-5 = data*weight), sums them, and accumulates across the beats of one output point.
- On the final beat it rounds the Q(2F) accumulator back to BIT_WIDTH fixed point with saturation.
- Presents the result on a valid/ready stream to the activation/feature-map writer.

---
 rtl/mac_reduce_accumulate_if.sv | 35 +++
 rtl/mac_reduce_accumulate.sv | 133 +++++++++++++
 tb/tb_mac_reduce_accumulate.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_reduce_accumulate_if.sv
// Product-beat input stream and rounded-result output stream of mac_reduce_accumulate.
// master = multiply stage / result consumer side, slave = the reducer.
interface mac_reduce_accumulate_if #(
  parameter int BIT_WIDTH = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_last;
  logic signed [2*BIT_WIDTH-1:0] mul_result_0;
  logic signed [2*BIT_WIDTH-1:0] mul_result_1;
  logic signed [2*BIT_WIDTH-1:0] mul_result_2;
  logic signed [2*BIT_WIDTH-1:0] mul_result_3;
  logic signed [2*BIT_WIDTH-1:0] mul_result_4;
  logic signed [2*BIT_WIDTH-1:0] mul_result_5;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [BIT_WIDTH-1:0]   out_data;
  logic                          out_sat;

  modport master (
    output in_valid, in_last,
    output mul_result_0, mul_result_1, mul_result_2,
    output mul_result_3, mul_result_4, mul_result_5,
    output out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_last,
    input  mul_result_0, mul_result_1, mul_result_2,
    input  mul_result_3, mul_result_4, mul_result_5,
    input  out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_reduce_accumulate.sv
// Sums six signed products per beat, accumulates a group of beats, then rounds and
// saturates to BIT_WIDTH. Define RELU_EN to clamp negative results to zero.
module mac_reduce_accumulate #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mac_reduce_accumulate_if.slave  bus
);
  localparam int PW = 2 * BIT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] HALF =
    {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  state_t                        state_reg, state_next;
  logic signed [PW-1:0]          prod [6];
  logic signed [ACC_WIDTH-1:0]   prod_ext [6];
  logic signed [ACC_WIDTH-1:0]   beat_sum;
  logic                          s1_valid_reg;
  logic                          s1_last_reg;
  logic signed [ACC_WIDTH-1:0]   s1_sum_reg;
  logic signed [ACC_WIDTH-1:0]   acc_reg;
  logic                          out_valid_reg;
  logic signed [BIT_WIDTH-1:0]   out_data_reg;
  logic                          out_sat_reg;
  logic                          adv;
  logic                          acc_en;
  logic                          load_out;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [ACC_WIDTH-1:0]   rnd_sum;
  logic signed [ACC_WIDTH-1:0]   rnd;
  logic signed [BIT_WIDTH-1:0]   res_data;
  logic                          res_sat;

  // A result stuck at the output freezes the whole pipe.
  assign adv           = ~(out_valid_reg & ~bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sat   = out_sat_reg;

  assign prod[0] = bus.mul_result_0;
  assign prod[1] = bus.mul_result_1;
  assign prod[2] = bus.mul_result_2;
  assign prod[3] = bus.mul_result_3;
  assign prod[4] = bus.mul_result_4;
  assign prod[5] = bus.mul_result_5;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_ext
      assign prod_ext[gi] = {{(ACC_WIDTH-PW){prod[gi][PW-1]}}, prod[gi]};
    end
  endgenerate

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < 6; i++) begin
      beat_sum = beat_sum + prod_ext[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (acc_en) begin
      state_next = s1_last_reg ? ST_IDLE : ST_ACC;
    end
  end

  always_comb begin
    acc_en   = s1_valid_reg & adv;
    load_out = acc_en & s1_last_reg;
    acc_next = (state_reg == ST_IDLE) ? s1_sum_reg : acc_reg + s1_sum_reg;
    rnd_sum  = acc_next + HALF;
    rnd      = rnd_sum >>> FRAC_BITS;
    res_data = rnd[BIT_WIDTH-1:0];
    res_sat  = 1'b0;
    if (rnd > SAT_MAX) begin
      res_data = SAT_MAX[BIT_WIDTH-1:0];
      res_sat  = 1'b1;
    end else if (rnd < SAT_MIN) begin
      res_data = SAT_MIN[BIT_WIDTH-1:0];
      res_sat  = 1'b1;
    end
`ifdef RELU_EN
    if (rnd[ACC_WIDTH-1]) begin
      res_data = '0;
      res_sat  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_sum_reg    <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (adv) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum_reg  <= beat_sum;
        s1_last_reg <= bus.in_last;
      end
      if (acc_en) begin
        acc_reg <= acc_next;
      end
      // Clears on handshake unless a fresh result lands on the same edge.
      out_valid_reg <= load_out;
      if (load_out) begin
        out_data_reg <= res_data;
        out_sat_reg  <= res_sat;
      end
    end
  end
endmodule

// File: tb/tb_mac_reduce_accumulate.sv
// Scoreboard bench for mac_reduce_accumulate: directed plan cases plus random groups
// under random back-pressure, checked against a longint reference model.
module tb_mac_reduce_accumulate;
  localparam int BW = 16;
  localparam int FB = 8;
  localparam int AW = 40;

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   ready_mode = 1;
  longint group_sum = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mac_reduce_accumulate_if #(.BIT_WIDTH(BW)) bus ();

  mac_reduce_accumulate #(.BIT_WIDTH(BW), .FRAC_BITS(FB), .ACC_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer sum of the group, round half up, clip to 16 bits.
  function automatic exp_t model_result(input longint s);
    exp_t   e;
    longint r;
    longint maxv;
    longint minv;
    maxv = (64'sd1 <<< (BW-1)) - 1;
    minv = -(64'sd1 <<< (BW-1));
    r = (s + (64'sd1 <<< (FB-1))) >>> FB;
    if (r > maxv) begin
      e.data = int'(maxv); e.sat = 1'b1;
    end else if (r < minv) begin
`ifdef RELU_EN
      e.data = 0; e.sat = 1'b0;
`else
      e.data = int'(minv); e.sat = 1'b1;
`endif
    end else begin
      e.data = int'(r); e.sat = 1'b0;
`ifdef RELU_EN
      if (r < 0) e.data = 0;
`endif
    end
    return e;
  endfunction

  task automatic beat(input int p[6], input bit last, input bit use_const,
                      input int cdata, input bit csat);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    bus.mul_result_0 = p[0];
    bus.mul_result_1 = p[1];
    bus.mul_result_2 = p[2];
    bus.mul_result_3 = p[3];
    bus.mul_result_4 = p[4];
    bus.mul_result_5 = p[5];
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 6; i++) group_sum += longint'(p[i]);
    if (last) begin
      if (use_const) begin
        e.data = cdata; e.sat = csat;
      end else begin
        e = model_result(group_sum);
      end
      sb.push_back(e);
      group_sum = 0;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic single(input int p0, input int cdata, input bit csat);
    int p[6];
    p = '{p0, 0, 0, 0, 0, 0};
    beat(p, 1'b1, 1'b1, cdata, csat);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int rprod();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 200000)) - 100000;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks hold during stalls.
  initial begin
    bit          prev_stall;
    logic [15:0] prev_data;
    logic        prev_sat;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_sat   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", $signed(bus.out_data), $signed(prev_data));
        check("hold_sat", bus.out_sat, prev_sat);
      end
      if (sb.size() == 0) begin
        check("spurious_valid", bus.out_valid, 0);
      end else if (bus.out_valid && bus.out_ready) begin
        e = sb.pop_front();
        n_out++;
        $display("out #%0d data=%0d sat=%0d (exp %0d/%0d)", n_out,
                 $signed(bus.out_data), bus.out_sat, e.data, e.sat);
        check("out_data", $signed(bus.out_data), e.data);
        check("out_sat", bus.out_sat, e.sat);
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      prev_sat   = bus.out_sat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int p[6];
    int big[6];
    int len;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mul_result_0 = '0; bus.mul_result_1 = '0; bus.mul_result_2 = '0;
    bus.mul_result_3 = '0; bus.mul_result_4 = '0; bus.mul_result_5 = '0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single beat, latency of two edges
    single(65536, 256, 1'b0);
    @(negedge clk);
    check("lat_after_e0", bus.out_valid, 0);
    @(negedge clk);
    check("lat_after_e1", bus.out_valid, 1);
    drain();

    // Three-beat group
    p = '{65536, 65536, 65536, 65536, 65536, 65536};
    beat(p, 1'b0, 1'b1, 0, 1'b0);
    beat(p, 1'b0, 1'b1, 0, 1'b0);
    beat(p, 1'b1, 1'b1, 4608, 1'b0);
    drain();

    // Rounding boundaries
    single(128, 1, 1'b0);
    single(127, 0, 1'b0);
    single(-128, 0, 1'b0);
`ifdef RELU_EN
    single(-129, 0, 1'b0);
`else
    single(-129, -1, 1'b0);
`endif
    drain();

    // Saturation both ways
    big = '{32'h3FFF0000, 32'h3FFF0000, 32'h3FFF0000,
            32'h3FFF0000, 32'h3FFF0000, 32'h3FFF0000};
    beat(big, 1'b1, 1'b1, 32767, 1'b1);
    for (int i = 0; i < 6; i++) big[i] = -big[i];
`ifdef RELU_EN
    beat(big, 1'b1, 1'b1, 0, 1'b0);
`else
    beat(big, 1'b1, 1'b1, -32768, 1'b1);
`endif
    drain();

    // Back-pressure: result held 5 cycles while a second group queues behind it
    ready_mode = 2;
    fork
      begin
        single(65536, 256, 1'b0);
        p = '{65536, 65536, 65536, 65536, 65536, 65536};
        beat(p, 1'b0, 1'b1, 0, 1'b0);
        beat(p, 1'b0, 1'b1, 0, 1'b0);
        beat(p, 1'b1, 1'b1, 4608, 1'b0);
      end
      begin
        for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
        check("bp_valid_seen", bus.out_valid, 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", bus.in_ready, 0);
        end
        ready_mode = 1;
      end
    join
    drain();

    // Reset in the middle of a group
    p = '{65536, 65536, 65536, 65536, 65536, 65536};
    beat(p, 1'b0, 1'b1, 0, 1'b0);
    beat(p, 1'b0, 1'b1, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    group_sum = 0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    single(65536, 256, 1'b0);
    drain();

    // Random groups under random back-pressure
    ready_mode = 0;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < 6; i++) p[i] = rprod();
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        beat(p, (b == len - 1), 1'b0, 0, 1'b0);
      end
    end
    ready_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
